// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM-stage data-memory access controller with request/grant/response bus
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [1:0]  size_i,
    input  logic        sext_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  MemtoReg_i,
    input  logic        RegWr_i,
    output logic        stall_o,
    output logic [1:0]  MemtoReg_o,
    output logic        RegWr_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic        is_mem, misaligned, timeout_hit, to_err;
    logic [3:0]  be;
    logic [31:0] wd, ld_fmt;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign is_mem      = in_valid & (MemRead_i | MemWrite_i);
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        case (size_i)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr_i[0];
            default: misaligned = |addr_i[1:0];
        endcase
    end

    // Store lane steering: data replicated so every enabled lane carries it
    always_comb begin
        case (size_i)
            2'b00: begin
                be = 4'b0001 << addr_i[1:0];
                wd = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be = addr_i[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_i[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = wdata_i;
            end
        endcase
    end

    always_comb begin
        case (addr_i[1:0])
            2'b00:   byte_sel = rdata_q[7:0];
            2'b01:   byte_sel = rdata_q[15:8];
            2'b10:   byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase
        half_sel = addr_i[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (size_i)
            2'b00:   ld_fmt = {{24{sext_i & byte_sel[7]}}, byte_sel};
            2'b01:   ld_fmt = {{16{sext_i & half_sel[15]}}, half_sel};
            default: ld_fmt = rdata_q;
        endcase
    end

    // Progress from the bus always beats an expiring timeout in the same cycle
    always_comb begin
        state_nxt = state;
        to_err    = 1'b0;
        case (state)
            S_IDLE: if (is_mem && !misaligned) state_nxt = S_REQ;
            S_REQ: begin
                if (mem_gnt) begin
                    state_nxt = MemWrite_i ? S_DONE : S_WAIT;
                end else if (timeout_hit) begin
                    state_nxt = S_DONE;
                    to_err    = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = S_DONE;
                end else if (timeout_hit) begin
                    state_nxt = S_DONE;
                    to_err    = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_REQ || state == S_WAIT) begin
                cnt   <= cnt + CNT_W'(1);
                err_q <= to_err;
            end else begin
                cnt <= '0;
            end
            if (state == S_IDLE) err_q <= 1'b0;
            if (state == S_WAIT && mem_rvalid) rdata_q <= mem_rdata;
        end
    end

    always_comb begin
        stall_o     = 1'b0;
        MemtoReg_o  = 2'b00;
        RegWr_o     = 1'b0;
        load_data_o = '0;
        misalign_o  = 1'b0;
        bus_err_o   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_be      = '0;
        mem_wdata   = '0;
        if (!reset) begin
            case (state)
                S_IDLE: begin
                    if (!is_mem) begin
                        MemtoReg_o = MemtoReg_i;
                        RegWr_o    = RegWr_i & in_valid;
                    end else if (misaligned) begin
                        misalign_o = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                    end
                end
                S_REQ: begin
                    stall_o   = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = MemWrite_i;
                    mem_addr  = {addr_i[31:2], 2'b00};
                    mem_be    = be;
                    mem_wdata = wd;
                end
                S_WAIT: stall_o = 1'b1;
                default: begin
                    MemtoReg_o  = MemtoReg_i;
                    RegWr_o     = RegWr_i & ~err_q;
                    bus_err_o   = err_q;
                    load_data_o = (err_q || MemWrite_i) ? 32'h0 : ld_fmt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized self-checking bench for mem_access_stage
module tb_mem_access_stage;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, MemRead_i, MemWrite_i, sext_i, RegWr_i;
    logic [1:0]  size_i, MemtoReg_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, RegWr_o, misalign_o, bus_err_o;
    logic [1:0]  MemtoReg_o;
    logic [31:0] load_data_o;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .size_i(size_i), .sext_i(sext_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .MemtoReg_i(MemtoReg_i), .RegWr_i(RegWr_i), .stall_o(stall_o),
        .MemtoReg_o(MemtoReg_o), .RegWr_o(RegWr_o), .load_data_o(load_data_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    logic [107:0] all_out;
    logic [6:0]   ctl;
    assign all_out = {stall_o, MemtoReg_o, RegWr_o, load_data_o, misalign_o, bus_err_o,
                      mem_req, mem_we, mem_addr, mem_be, mem_wdata};
    assign ctl = {stall_o, mem_req, RegWr_o, MemtoReg_o, bus_err_o, misalign_o};

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 4'(32'd1 << (a % 4));
        if (sz == 2'd1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return (w & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sx,
                                             input logic [31:0] a, input logic [31:0] r);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (r >> (8 * (a % 4))) & 32'hFF;
            if (sx && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (r >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (sx && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = r;
        end
        return v;
    endfunction

    function automatic logic ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0);
    endfunction

    task automatic drive_idle();
        @(posedge clk); #1;
        in_valid = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    // One memory instruction from its IDLE cycle through DONE; gd/rd are
    // empty REQ/WAIT cycles before gnt/rvalid (gd >= TIMEOUT means never).
    task automatic do_op(input logic st, input logic both, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] w, input int gd, input int rd,
                         input logic [31:0] rdat, input logic rw, input logic [1:0] m2r,
                         input string tag);
        logic        tout;
        int          n_rw, req_cyc, rv_cyc;
        logic [6:0]  exp;
        logic [31:0] exp_ld;
        @(posedge clk); #1;
        in_valid = 1'b1; MemWrite_i = st; MemRead_i = st ? both : 1'b1;
        size_i = sz; sext_i = sx; addr_i = a; wdata_i = w; RegWr_i = rw; MemtoReg_i = m2r;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if (ref_misaligned(sz, a)) begin
            @(negedge clk);
            checks++;
            if (ctl !== 7'b0000001) begin
                errors++;
                $display("FAIL %s misalign ctl: got %b exp %b", tag, ctl, 7'b0000001);
            end
            return;
        end
        tout    = st ? (gd + 1 > TIMEOUT) : (gd + 1 > TIMEOUT || gd + rd + 2 > TIMEOUT);
        n_rw    = tout ? TIMEOUT : (st ? gd + 1 : gd + rd + 2);
        req_cyc = (gd + 1 > TIMEOUT) ? TIMEOUT : gd + 1;
        rv_cyc  = gd + rd + 2;
        exp_ld  = (st || tout) ? 32'h0 : ref_load(sz, sx, a, rdat);
        @(negedge clk);
        checks++;
        if (ctl !== 7'b1000000) begin
            errors++;
            $display("FAIL %s idle ctl: got %b exp %b", tag, ctl, 7'b1000000);
        end
        for (int c = 1; c <= n_rw + 1; c++) begin
            @(posedge clk); #1;
            mem_gnt = (c == gd + 1);
            if (!st && c == rv_cyc) begin
                mem_rvalid = 1'b1; mem_rdata = rdat;
            end else begin
                mem_rvalid = (c <= req_cyc) ? 1'($urandom % 2) : 1'b0;
                mem_rdata  = $urandom;
            end
            @(negedge clk);
            if (c <= n_rw) begin
                exp = {1'b1, (c <= req_cyc), 1'b0, 2'b00, 1'b0, 1'b0};
                checks++;
                if (ctl !== exp) begin
                    errors++;
                    $display("FAIL %s stall ctl c=%0d: got %b exp %b", tag, c, ctl, exp);
                end
                if (c <= req_cyc) begin
                    checks++;
                    if ({mem_we, mem_addr, mem_be} !== {st, a - (a % 4), ref_be(sz, a)}) begin
                        errors++;
                        $display("FAIL %s bus c=%0d: got we=%b addr=%h be=%b exp we=%b addr=%h be=%b",
                                 tag, c, mem_we, mem_addr, mem_be, st, a - (a % 4), ref_be(sz, a));
                    end
                    if (st) begin
                        checks++;
                        if (mem_wdata !== ref_wdata(sz, w)) begin
                            errors++;
                            $display("FAIL %s wdata c=%0d: got %h exp %h", tag, c, mem_wdata,
                                     ref_wdata(sz, w));
                        end
                    end
                end
            end else begin
                exp = {1'b0, 1'b0, rw & ~tout, m2r, tout, 1'b0};
                checks++;
                if (ctl !== exp) begin
                    errors++;
                    $display("FAIL %s done ctl: got %b exp %b", tag, ctl, exp);
                end
                checks++;
                if (load_data_o !== exp_ld) begin
                    errors++;
                    $display("FAIL %s load_data: got %h exp %h", tag, load_data_o, exp_ld);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'($urandom % 2);
            size_i = 2'($urandom); sext_i = 1'b1; addr_i = $urandom; wdata_i = $urandom;
            RegWr_i = 1'b1; MemtoReg_i = 2'b11; mem_gnt = 1'b1; mem_rvalid = 1'b1;
            mem_rdata = $urandom;
            @(negedge clk);
            checks++;
            if (all_out !== '0) begin
                errors++;
                $display("FAIL reset outputs: got %h exp 0", all_out);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic test_pass_through();
        logic [6:0] exp;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                in_valid = 1'b1; RegWr_i = 1'b1; MemtoReg_i = 2'b01;
                MemRead_i = 1'b0; MemWrite_i = 1'b0;
            end else begin
                in_valid = 1'($urandom % 2); RegWr_i = 1'($urandom % 2); MemtoReg_i = 2'($urandom);
                MemRead_i = in_valid ? 1'b0 : 1'($urandom % 2);
                MemWrite_i = in_valid ? 1'b0 : 1'($urandom % 2);
            end
            addr_i = $urandom; size_i = 2'($urandom);
            exp = {1'b0, 1'b0, RegWr_i & in_valid, MemtoReg_i, 1'b0, 1'b0};
            @(negedge clk);
            checks++;
            if (ctl !== exp) begin
                errors++;
                $display("FAIL pass_through %0d ctl: got %b exp %b", i, ctl, exp);
            end
        end
    endtask

    task automatic test_directed();
        do_op(1'b0, 1'b0, 2'd0, 1'b1, 32'h1003, $urandom, 0, 1, 32'h80FFFFFF, 1'b1, 2'b01, "lb_sext");
        do_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h2002, 32'h0000BEEF, 3, 0, 32'h0, 1'b0, 2'b00, "sh");
        do_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h3001, $urandom, 0, 0, 32'h0, 1'b1, 2'b01, "lw_misalign");
        do_op(1'b0, 1'b0, 2'd1, 1'b0, 32'h1235, $urandom, 0, 0, 32'h0, 1'b1, 2'b01, "lh_misalign");
        do_op(1'b0, 1'b0, 2'd1, 1'b1, 32'h0102, $urandom, 1, 0, 32'h8001_7FFF, 1'b1, 2'b01, "lh_hi");
        do_op(1'b1, 1'b1, 2'd0, 1'b0, 32'h0051, 32'h1234_56A5, 0, 0, 32'h0, 1'b0, 2'b00, "sb_both");
    endtask

    task automatic test_timeout();
        do_op(1'b0, 1'b0, 2'd1, 1'b0, 32'h4000, $urandom, 99, 0, 32'h0, 1'b1, 2'b01, "lhu_timeout");
        @(posedge clk); #1;
        in_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if ({stall_o, mem_req, load_data_o} !== 34'h0) begin
            errors++;
            $display("FAIL late_rvalid: got stall=%b req=%b ld=%h exp 0", stall_o, mem_req, load_data_o);
        end
        do_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h0040, $urandom, 0, 14, 32'hCAFEF00D, 1'b1, 2'b01, "lw_edge_ok");
        do_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h0044, $urandom, 0, 15, 32'hCAFEF00D, 1'b1, 2'b01, "lw_edge_to");
        do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0048, $urandom, 15, 0, 32'h0, 1'b1, 2'b00, "sw_edge_ok");
        do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h004C, $urandom, 16, 0, 32'h0, 1'b1, 2'b00, "sw_edge_to");
    endtask

    task automatic test_reset_in_wait();
        @(posedge clk); #1;
        in_valid = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0; size_i = 2'd2; addr_i = 32'h20;
        RegWr_i = 1'b1; MemtoReg_i = 2'b01; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(posedge clk); #1; mem_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if ({stall_o, mem_req} !== 2'b11) begin
            errors++;
            $display("FAIL rst_wait req: got %b exp 11", {stall_o, mem_req});
        end
        @(posedge clk); #1; mem_gnt = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL rst_wait during reset: got %h exp 0", all_out);
        end
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555AAAA;
        @(negedge clk);
        checks++;
        if ({stall_o, mem_req, RegWr_o} !== 3'b000) begin
            errors++;
            $display("FAIL rst_wait after: got %b exp 000", {stall_o, mem_req, RegWr_o});
        end
        do_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h10, $urandom, 0, 0, 32'h1357_9BDF, 1'b1, 2'b01, "lw_after_rst");
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < 30; i++) begin
            sz = 2'($urandom);
            a  = $urandom;
            if ($urandom % 4 != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz >= 2'd2) a[1:0] = 2'b00;
            end
            do_op(1'($urandom % 2), 1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom,
                  int'($urandom % 4), int'($urandom % 4), $urandom, 1'($urandom % 2),
                  2'($urandom), "rand");
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; size_i = 2'd0;
        sext_i = 1'b0; addr_i = '0; wdata_i = '0; MemtoReg_i = 2'b00; RegWr_i = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        test_reset();
        test_pass_through();
        test_directed();
        test_timeout();
        test_reset_in_wait();
        test_back_to_back();
        drive_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage data-memory access controller in the 5-stage MIPS pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB register. The MEM/WB register captures every clock and has no enable.
- Performs byte, halfword and word loads/stores over a request/grant/response memory bus, and stalls upstream while an access is outstanding.
- Hands the MEM/WB register either a completed instruction or a bubble each cycle.

Parameters:
- TIMEOUT, 16: maximum cycles spent in REQ+WAIT before aborting with bus error. Must be ≥2.
- CNT_W, 5: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present from EX/MEM.
- MemRead_i  in  1  load.
- MemWrite_i  in  1  store. Has priority if both MemRead_i and MemWrite_i are set.
- size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- sext_i  in  1  sign-extend loaded byte/half (lb/lh) vs zero-extend (lbu/lhu).
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, right-aligned.
- MemtoReg_i  in  2  writeback select, passed through.
- RegWr_i  in  1  register write enable, passed through.
- stall_o  out  1  hold EX/MEM and earlier stages.
- MemtoReg_o  out  2  to MEM/WB.
- RegWr_o  out  1  to MEM/WB.
- load_data_o  out  32  formatted load result.
- misalign_o  out  1  misaligned-access pulse.
- bus_err_o  out  1  timeout pulse.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address ({addr_i[31:2],2'b00}).
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.

Behaviour:
- Clocking and reset: single clock domain. Synchronous active-high reset, sampled on the rising edge of clk.
  - Reset returns the FSM to IDLE and clears the counter, the rdata register and the error flags.
  - While reset is high, every output is 0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - No in_valid, or neither MemRead_i nor MemWrite_i: pass-through. MemtoReg_o/RegWr_o = inputs (RegWr_o = RegWr_i & in_valid), stall_o=0, no request.
  - Memory op, misaligned (half with addr[0]=1; word with addr[1:0]≠0): no request. misalign_o=1 for that cycle, RegWr_o=0, MemtoReg_o=00, stall_o=0.
  - Memory op, aligned: go to REQ, stall_o=1, bubble (RegWr_o=0, MemtoReg_o=00).
- REQ:
  - mem_req=1; mem_we, mem_be and mem_wdata are driven from the held inputs. stall_o=1, bubble.
  - On mem_gnt: a store goes to DONE; a load goes to WAIT.
- WAIT:
  - mem_req=0, stall_o=1, bubble.
  - On mem_rvalid: mem_rdata is captured into a register; go to DONE.
- DONE (one cycle):
  - stall_o=0. MemtoReg_o=MemtoReg_i, RegWr_o=RegWr_i.
  - load_data_o is formatted from the captured data for loads, 0 for stores.
  - Next state is IDLE.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When the count reaches TIMEOUT-1 without progressing: go to DONE with bus_err_o=1 in the DONE cycle, RegWr_o=0, load_data_o=0.
  - If mem_gnt or mem_rvalid arrives in that same cycle, the normal transition wins.
- Input hold: upstream holds all *_i stable while stall_o=1. The block does not re-register them.
- Byte lanes (little-endian, k=addr[1:0]):
  - Byte: be=1<<k, wdata replicated 4×.
  - Half: be=0011 if addr[1]=0, else 1100; wdata half replicated 2×.
  - Word: be=1111.
  - Loads select the lane by k (byte) or addr[1] (half), then sign- or zero-extend to 32 bits per sext_i.
- Latency from an aligned op's IDLE cycle: store = 1 + (cycles to gnt) + 1 DONE cycle. Load additionally includes the cycles to rvalid. Minimum total stall: 2 cycles for a store, 3 for a load.
- mem_rvalid outside WAIT is ignored. This covers late responses after a timeout or reset.
- No back-to-back overlap: the next instruction is sampled in IDLE only.

Test Plan:
- Non-memory: in_valid=1, RegWr_i=1, MemtoReg_i=01 → same cycle RegWr_o=1, MemtoReg_o=01, stall_o=0, mem_req=0.
- lb sext, addr=0x1003: gnt on the 1st REQ cycle, rvalid 2 cycles later with rdata=0x80FFFFFF → load_data_o=0xFFFFFF80 in DONE; stall_o high exactly 4 cycles; RegWr_o=0 during the stall.
- sh, addr=0x2002, wdata=0x0000BEEF, gnt delayed 3 cycles → mem_be=1100, mem_wdata=0xBEEFBEEF, mem_addr=0x2000, mem_req held for 4 cycles.
- lw at addr=0x3001 → misalign_o=1 for 1 cycle, mem_req=0, RegWr_o=0, stall_o=0.
- lhu, addr=0x4000, gnt never arrives, TIMEOUT=16 → after 16 REQ cycles DONE with bus_err_o=1, RegWr_o=0; a late rvalid afterwards is ignored.
- reset asserted in WAIT → next cycle IDLE, mem_req=0, stall_o=0; the following lw at 0x10 completes normally.
